// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdId,
        StWtId,
        StRdTs,
        StWtTs,
        StEval,
        StHold
    } sysid_chk_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h57A0_DED5;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read path between the checker (master) and the system-ID slave.
interface sysid_checker_if;

    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_checker.sv
// Reads the system-ID and build-timestamp words and compares them against the
// values built into the bitstream; optionally repeats the check periodically.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned RECHECK_PERIOD = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    sysid_checker_if.master avm,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            id_err,
    output logic            ts_err,
    output logic [31:0]     id_value,
    output logic [31:0]     ts_value
);

    if (READ_LATENCY > 3) begin : gen_bad_latency
        $error("sysid_checker: READ_LATENCY must be in the range 0..3");
    end

    localparam int unsigned LatW = $clog2(READ_LATENCY) + 1;
    localparam int unsigned PerW = $clog2(RECHECK_PERIOD) + 1;
    localparam bit HasLat     = (READ_LATENCY != 0);
    localparam bit HasRecheck = (RECHECK_PERIOD != 0);
    localparam logic [LatW-1:0] LatLast = LatW'(READ_LATENCY);
    // The EVAL cycle counts as period cycle 0, so HOLD starts at 1.
    localparam logic [PerW-1:0] PerLast  = HasRecheck ? PerW'(RECHECK_PERIOD - 1) : '0;
    localparam logic [PerW-1:0] PerFirst = (RECHECK_PERIOD > 1) ? PerW'(1) : '0;

    sysid_chk_state_t state_q, state_d;
    logic             auto_go_q, auto_go_d;
    logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
    logic [PerW-1:0]  per_cnt_q, per_cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             id_err_q, id_err_d;
    logic             ts_err_q, ts_err_d;
    logic [31:0]      id_value_q, id_value_d;
    logic [31:0]      ts_value_q, ts_value_d;

    always_comb begin
        state_d    = state_q;
        auto_go_d  = auto_go_q;
        lat_cnt_d  = lat_cnt_q;
        per_cnt_d  = per_cnt_q;
        done_d     = done_q;
        pass_d     = pass_q;
        id_err_d   = id_err_q;
        ts_err_d   = ts_err_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;

        unique case (state_q)
            StIdle: begin
                if (auto_go_q || start) begin
                    state_d   = StRdId;
                    auto_go_d = 1'b0;
                end
            end
            StRdId: begin
                if (HasLat) begin
                    lat_cnt_d = LatW'(1);
                    state_d   = StWtId;
                end else begin
                    id_value_d = avm.avm_readdata;
                    state_d    = StRdTs;
                end
            end
            StWtId: begin
                if (lat_cnt_q == LatLast) begin
                    id_value_d = avm.avm_readdata;
                    lat_cnt_d  = '0;
                    state_d    = StRdTs;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end
            StRdTs: begin
                if (HasLat) begin
                    lat_cnt_d = LatW'(1);
                    state_d   = StWtTs;
                end else begin
                    ts_value_d = avm.avm_readdata;
                    state_d    = StEval;
                end
            end
            StWtTs: begin
                if (lat_cnt_q == LatLast) begin
                    ts_value_d = avm.avm_readdata;
                    lat_cnt_d  = '0;
                    state_d    = StEval;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end
            StEval: begin
                id_err_d = (id_value_q != EXPECTED_ID);
                ts_err_d = (ts_value_q != EXPECTED_TS);
                pass_d   = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
                done_d   = 1'b1;
                if (HasRecheck) begin
                    per_cnt_d = PerFirst;
                    state_d   = StHold;
                end else begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (start || (per_cnt_q == PerLast)) begin
                    per_cnt_d = '0;
                    state_d   = StRdId;
                end else begin
                    per_cnt_d = per_cnt_q + PerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            auto_go_q  <= 1'b1;
            lat_cnt_q  <= '0;
            per_cnt_q  <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            id_err_q   <= 1'b0;
            ts_err_q   <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            auto_go_q  <= auto_go_d;
            lat_cnt_q  <= lat_cnt_d;
            per_cnt_q  <= per_cnt_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            id_err_q   <= id_err_d;
            ts_err_q   <= ts_err_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end

    // Address is decoded from state so it stays constant through the wait states.
    always_comb begin
        avm.avm_read    = (state_q == StRdId) || (state_q == StRdTs);
        avm.avm_address = ((state_q == StRdTs) || (state_q == StWtTs)) ? SYSID_ADDR_TS
                                                                       : SYSID_ADDR_ID;
        busy            = (state_q != StIdle) && (state_q != StHold);
    end

    assign done     = done_q;
    assign pass     = pass_q;
    assign id_err   = id_err_q;
    assign ts_err   = ts_err_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: four checker instances (default, latency 2, recheck 16, latency 3)
// each driven by its own small sysid slave model.
module tb_sysid_checker;

    localparam logic [31:0] TS_OK  = 32'h57A0_DED5;
    localparam logic [31:0] TS_BAD = 32'h57A0_DED4;
    localparam logic [31:0] ID3    = 32'h1234_5678;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [4];
    logic        start [4];
    logic        busy  [4];
    logic        done  [4];
    logic        pass  [4];
    logic        iderr [4];
    logic        tserr [4];
    logic [31:0] idv   [4];
    logic [31:0] tsv   [4];

    logic [31:0] ts0 = TS_OK;
    logic [31:0] ts2 = TS_OK;

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt0  = 0;

    sysid_checker_if if0 ();
    sysid_checker_if if1 ();
    sysid_checker_if if2 ();
    sysid_checker_if if3 ();

    sysid_checker u_dut0 (
        .clock(clk), .reset(rst[0]), .start(start[0]), .avm(if0.master),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .id_err(iderr[0]),
        .ts_err(tserr[0]), .id_value(idv[0]), .ts_value(tsv[0])
    );

    sysid_checker #(.READ_LATENCY(2)) u_dut1 (
        .clock(clk), .reset(rst[1]), .start(start[1]), .avm(if1.master),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .id_err(iderr[1]),
        .ts_err(tserr[1]), .id_value(idv[1]), .ts_value(tsv[1])
    );

    sysid_checker #(.RECHECK_PERIOD(16)) u_dut2 (
        .clock(clk), .reset(rst[2]), .start(start[2]), .avm(if2.master),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .id_err(iderr[2]),
        .ts_err(tserr[2]), .id_value(idv[2]), .ts_value(tsv[2])
    );

    sysid_checker #(.EXPECTED_ID(ID3), .READ_LATENCY(3)) u_dut3 (
        .clock(clk), .reset(rst[3]), .start(start[3]), .avm(if3.master),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .id_err(iderr[3]),
        .ts_err(tserr[3]), .id_value(idv[3]), .ts_value(tsv[3])
    );

    // Zero-latency slaves answer combinationally.
    assign if0.avm_readdata = if0.avm_address ? ts0 : 32'h0;
    assign if2.avm_readdata = if2.avm_address ? ts2 : 32'h0;

    // Registered slaves: data valid only READ_LATENCY cycles after the strobe.
    logic [1:0] p1 [2];
    logic [1:0] p3 [3];
    always @(posedge clk) begin
        p1[0] <= {if1.avm_read, if1.avm_address};
        p1[1] <= p1[0];
        p3[0] <= {if3.avm_read, if3.avm_address};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign if1.avm_readdata = p1[1][1] ? (p1[1][0] ? TS_OK : 32'h0) : JUNK;
    assign if3.avm_readdata = p3[2][1] ? (p3[2][0] ? TS_OK : ID3) : JUNK;

    always @(posedge clk) begin
        if (!rst[0] && if0.avm_read) rd_cnt0 <= rd_cnt0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        logic [31:0] rdv;
        logic [31:0] adv;
        rdv = 0;
        adv = 0;
        unique case (k)
            0: begin rdv = 32'(if0.avm_read); adv = 32'(if0.avm_address); end
            1: begin rdv = 32'(if1.avm_read); adv = 32'(if1.avm_address); end
            2: begin rdv = 32'(if2.avm_read); adv = 32'(if2.avm_address); end
            default: begin rdv = 32'(if3.avm_read); adv = 32'(if3.avm_address); end
        endcase
        check({tag, " read"}, rdv, 0);
        check({tag, " addr"}, adv, 0);
        check({tag, " busy"}, 32'(busy[k]), 0);
        check({tag, " done"}, 32'(done[k]), 0);
        check({tag, " pass"}, 32'(pass[k]), 0);
        check({tag, " id_err"}, 32'(iderr[k]), 0);
        check({tag, " ts_err"}, 32'(tserr[k]), 0);
        check({tag, " id_value"}, idv[k], 0);
        check({tag, " ts_value"}, tsv[k], 0);
    endtask

    initial begin
        int base;
        for (int k = 0; k < 4; k++) begin
            rst[k]   = 1'b1;
            start[k] = 1'b0;
        end
        ticks(2);

        // Default instance: reset values, then the automatic check.
        check_reset_vals(0, "d0 reset");
        rst[0] = 1'b0;
        check("d0 c0 read", 32'(if0.avm_read), 0);
        check("d0 c0 busy", 32'(busy[0]), 0);
        tick();
        check("d0 c1 read", 32'(if0.avm_read), 1);
        check("d0 c1 addr", 32'(if0.avm_address), 0);
        check("d0 c1 busy", 32'(busy[0]), 1);
        tick();
        check("d0 c2 read", 32'(if0.avm_read), 1);
        check("d0 c2 addr", 32'(if0.avm_address), 1);
        tick();
        check("d0 c3 read", 32'(if0.avm_read), 0);
        check("d0 c3 busy", 32'(busy[0]), 1);
        check("d0 c3 done", 32'(done[0]), 0);
        tick();
        check("d0 c4 busy", 32'(busy[0]), 0);
        check("d0 c4 done", 32'(done[0]), 1);
        check("d0 c4 pass", 32'(pass[0]), 1);
        check("d0 c4 id_err", 32'(iderr[0]), 0);
        check("d0 c4 ts_err", 32'(tserr[0]), 0);
        check("d0 c4 id_value", idv[0], 0);
        check("d0 c4 ts_value", tsv[0], TS_OK);

        // Wrong timestamp via start in IDLE; result changes only after EVAL.
        ts0 = TS_BAD;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        check("d0 bad rd_id read", 32'(if0.avm_read), 1);
        ticks(2);
        check("d0 bad eval busy", 32'(busy[0]), 1);
        check("d0 bad eval pass held", 32'(pass[0]), 1);
        tick();
        check("d0 bad pass", 32'(pass[0]), 0);
        check("d0 bad ts_err", 32'(tserr[0]), 1);
        check("d0 bad id_err", 32'(iderr[0]), 0);
        check("d0 bad ts_value", tsv[0], TS_BAD);
        check("d0 bad done", 32'(done[0]), 1);

        // start while busy is dropped; start in IDLE runs one read pair.
        ts0 = TS_OK;
        base = rd_cnt0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        ticks(2);
        check("d0 busy-start eval busy", 32'(busy[0]), 1);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        ticks(4);
        check("d0 busy-start reads", 32'(rd_cnt0 - base), 2);
        check("d0 busy-start idle", 32'(busy[0]), 0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        ticks(6);
        check("d0 idle-start reads", 32'(rd_cnt0 - base), 4);
        check("d0 idle-start pass", 32'(pass[0]), 1);

        // READ_LATENCY=2: strobes at c1/c4, EVAL at c7, junk never captured.
        rst[1] = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            check($sformatf("d1 c%0d read", c), 32'(if1.avm_read), 32'((c == 1) || (c == 4)));
            check($sformatf("d1 c%0d addr", c), 32'(if1.avm_address),
                  32'((c >= 4) && (c <= 6)));
            check($sformatf("d1 c%0d busy", c), 32'(busy[1]), 32'((c >= 1) && (c <= 7)));
            check($sformatf("d1 c%0d done", c), 32'(done[1]), 32'(c == 8));
            if (c < 8) tick();
        end
        check("d1 pass", 32'(pass[1]), 1);
        check("d1 id_value", idv[1], 0);
        check("d1 ts_value", tsv[1], TS_OK);

        // RECHECK_PERIOD=16: first EVAL c3, second check strobes at c19/c20.
        rst[2] = 1'b0;
        for (int c = 0; c <= 22; c++) begin
            check($sformatf("dr c%0d read", c), 32'(if2.avm_read),
                  32'((c == 1) || (c == 2) || (c == 19) || (c == 20)));
            check($sformatf("dr c%0d busy", c), 32'(busy[2]),
                  32'(((c >= 1) && (c <= 3)) || ((c >= 19) && (c <= 21))));
            check($sformatf("dr c%0d done", c), 32'(done[2]), 32'(c >= 4));
            check($sformatf("dr c%0d pass", c), 32'(pass[2]), 32'((c >= 4) && (c < 22)));
            check($sformatf("dr c%0d ts_err", c), 32'(tserr[2]), 32'(c >= 22));
            if (c == 4) ts2 = TS_BAD;
            if (c < 22) tick();
        end
        check("dr ts_value", tsv[2], TS_BAD);

        // READ_LATENCY=3: reset during WT_TS aborts, then a full rerun.
        rst[3] = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            check($sformatf("d3 c%0d read", c), 32'(if3.avm_read), 32'((c == 1) || (c == 5)));
            check($sformatf("d3 c%0d addr", c), 32'(if3.avm_address), 32'(c >= 5));
            check($sformatf("d3 c%0d busy", c), 32'(busy[3]), 32'(c >= 1));
            if (c < 7) tick();
        end
        check("d3 pre-reset id_value", idv[3], ID3);
        rst[3] = 1'b1;
        tick();
        check_reset_vals(3, "d3 mid-reset");
        rst[3] = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            check($sformatf("d3 rerun c%0d read", c), 32'(if3.avm_read),
                  32'((c == 1) || (c == 5)));
            check($sformatf("d3 rerun c%0d busy", c), 32'(busy[3]), 32'((c >= 1) && (c <= 9)));
            check($sformatf("d3 rerun c%0d done", c), 32'(done[3]), 32'(c == 10));
            if (c < 10) tick();
        end
        check("d3 rerun pass", 32'(pass[3]), 1);
        check("d3 rerun id_value", idv[3], ID3);
        check("d3 rerun ts_value", tsv[3], TS_OK);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
